// File: rtl/dsm_playback_ctrl.sv
// dsm_playback_ctrl: captures modulator words into an external buffer RAM and
// replays them on internal_bit for a programmed number of passes (or forever).
`timescale 1ns / 1ps
`default_nettype none

module dsm_playback_ctrl #(
  parameter int MOD_BITS  = 4,
  parameter int SAMPLES   = 256,
  parameter int ADDR_BITS = 8,
  parameter int LOOP_BITS = 8
) (
  input  logic                 internal_clk,
  input  logic                 internal_rst_n,
  input  logic                 start,
  input  logic                 replay,
  input  logic                 abort,
  input  logic [ADDR_BITS:0]   cfg_length,
  input  logic [LOOP_BITS-1:0] cfg_loops,
  input  logic                 src_valid,
  input  logic [MOD_BITS-1:0]  src_bit,
  output logic                 buf_wr_en,
  output logic [ADDR_BITS-1:0] buf_wr_addr,
  output logic [MOD_BITS-1:0]  buf_wr_data,
  output logic                 buf_rd_en,
  output logic [ADDR_BITS-1:0] buf_rd_addr,
  input  logic [MOD_BITS-1:0]  buf_rd_data,
  output logic [MOD_BITS-1:0]  internal_bit,
  output logic                 play_valid,
  output logic [2:0]           state,
  output logic [ADDR_BITS:0]   fill_count,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_PLAY = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [ADDR_BITS:0]   C_SAMPLES  = (ADDR_BITS + 1)'(SAMPLES);
  localparam logic [ADDR_BITS:0]   C_LEN_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] C_PTR_ONE  = ADDR_BITS'(1);
  localparam logic [LOOP_BITS-1:0] C_LOOP_ONE = LOOP_BITS'(1);

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   len_q, len_d;
  logic [LOOP_BITS-1:0] loops_q, loops_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOOP_BITS-1:0] loop_cnt_q, loop_cnt_d;
  logic [ADDR_BITS:0]   fill_count_q, fill_count_d;
  logic                 rd_q, rd_d;
  logic [MOD_BITS-1:0]  internal_bit_q, internal_bit_d;
  logic                 play_valid_q, play_valid_d;

  logic cfg_bad;
  logic wr_last;
  logic rd_last;
  logic loop_last;
  logic wr_fire;
  logic rd_fire;

  // Pointers are zero-extended so len==2**ADDR_BITS compares against 255, not 0.
  assign cfg_bad   = (cfg_length == '0) || (cfg_length > C_SAMPLES);
  assign wr_last   = ({1'b0, wr_ptr_q} == (len_q - C_LEN_ONE));
  assign rd_last   = ({1'b0, rd_ptr_q} == (len_q - C_LEN_ONE));
  assign loop_last = (loops_q != '0) && (loop_cnt_q == (loops_q - C_LOOP_ONE));

  assign wr_fire = internal_rst_n & ~abort & (state_q == ST_FILL) & src_valid;
  assign rd_fire = internal_rst_n & ~abort & (state_q == ST_PLAY);

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    loops_d        = loops_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    loop_cnt_d     = loop_cnt_q;
    fill_count_d   = fill_count_q;
    rd_d           = rd_fire;
    play_valid_d   = rd_q;
    internal_bit_d = rd_q ? buf_rd_data : '0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            len_d   = cfg_length;
            loops_d = cfg_loops;
            if (cfg_bad) begin
              state_d = ST_ERR;
            end else begin
              state_d      = ST_FILL;
              wr_ptr_d     = '0;
              fill_count_d = '0;
            end
          end else if (replay && (state_q == ST_DONE)) begin
            state_d    = ST_PLAY;
            rd_ptr_d   = '0;
            loop_cnt_d = '0;
          end
        end
        ST_FILL: begin
          if (src_valid) begin
            wr_ptr_d     = wr_ptr_q + C_PTR_ONE;
            fill_count_d = fill_count_q + C_LEN_ONE;
            if (wr_last) begin
              state_d    = ST_PLAY;
              rd_ptr_d   = '0;
              loop_cnt_d = '0;
            end
          end
        end
        ST_PLAY: begin
          if (rd_last) begin
            rd_ptr_d = '0;
            if (loops_q != '0) begin
              loop_cnt_d = loop_cnt_q + C_LOOP_ONE;
            end
            if (loop_last) begin
              state_d = ST_DONE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge internal_clk) begin
    if (!internal_rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      loops_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      loop_cnt_q     <= '0;
      fill_count_q   <= '0;
      rd_q           <= 1'b0;
      internal_bit_q <= '0;
      play_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      loops_q        <= loops_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      loop_cnt_q     <= loop_cnt_d;
      fill_count_q   <= fill_count_d;
      rd_q           <= rd_d;
      internal_bit_q <= internal_bit_d;
      play_valid_q   <= play_valid_d;
    end
  end

  assign buf_wr_en    = wr_fire;
  assign buf_wr_addr  = wr_ptr_q;
  assign buf_wr_data  = src_bit;
  assign buf_rd_en    = rd_fire;
  assign buf_rd_addr  = rd_ptr_q;
  assign internal_bit = internal_bit_q;
  assign play_valid   = play_valid_q;
  assign state        = state_q;
  assign fill_count   = fill_count_q;
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);

endmodule

`default_nettype wire
